// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: default frame parameters, FSM state encoding
// and the start-bit centring helper.
package uart_rx_pkg;

    localparam int UART_DATA_WIDTH   = 8;
    localparam int UART_CLKS_PER_BIT = 1085;  // 125 MHz sysclk / 115200 baud

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Count at which the start bit is re-checked, roughly at its centre.
    function automatic int mid_count(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// The reset value is a parameter so that idle-high and idle-low lines can share it.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with start-bit centring, framing-error
// detection and a break state that waits for the line to return high.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = UART_DATA_WIDTH
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  i_rx_en,
    input  logic                  i_rx_serial,
    output logic [DATA_WIDTH-1:0] o_rx_byte,
    output logic                  o_rx_dv,
    output logic                  o_rx_ferr,
    output logic                  o_rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(mid_count(CLKS_PER_BIT));
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  rx_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(sysclk),
        .rst(rst),
        .d  (i_rx_serial),
        .q  (rx_s)
    );

    assign o_rx_busy = (state != ST_IDLE);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            o_rx_byte <= '0;
            o_rx_dv   <= 1'b0;
            o_rx_ferr <= 1'b0;
        end else begin
            o_rx_dv   <= 1'b0;
            o_rx_ferr <= 1'b0;
            // Disabling the receiver abandons any frame in progress without a pulse.
            if (!i_rx_en && state != ST_IDLE) begin
                state <= ST_IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_rx_en && !rx_s) begin
                            state <= ST_START;
                            cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (cnt == CNT_MID) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            shift[idx] <= rx_s;
                            if (idx == IDX_LAST) begin
                                idx   <= '0;
                                state <= ST_STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                o_rx_byte <= shift;
                                o_rx_dv   <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                o_rx_ferr <= 1'b1;
                                state     <= ST_BREAK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int DW   = 8;
    localparam int HALF = (CPB - 1) / 2;
    // Line reaches the FSM two edges late, one edge leaves idle, HALF+1 edges
    // reach the start-bit centre, then 8 data bits and the stop bit at CPB each.
    localparam int DV_LATENCY = 2 + 1 + (HALF + 1) + 9 * CPB;

    logic          sysclk = 1'b0;
    logic          rst;
    logic          en;
    logic          rx;
    logic [DW-1:0] rx_byte;
    logic          dv;
    logic          ferr;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int ferr_cnt = 0;
    int last_dv_cyc = 0;
    int frame_cyc = 0;
    logic prev_dv = 1'b0;
    logic prev_ferr = 1'b0;
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap;
        logic [7:0] exp_byte;
        int         exp_dv;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (DW)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .i_rx_en    (en),
        .i_rx_serial(rx),
        .o_rx_byte  (rx_byte),
        .o_rx_dv    (dv),
        .o_rx_ferr  (ferr),
        .o_rx_busy  (busy)
    );

    always #4 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Pulse monitor: collects received bytes and polices pulse shape.
    always @(negedge sysclk) begin
        if (dv && ferr) begin
            fails++;
            $display("FAIL pulse_overlap: dv=%0b ferr=%0b, required never both high", dv, ferr);
        end
        if (dv && prev_dv) begin
            fails++;
            $display("FAIL dv_width: dv high two cycles at cycle %0d, required one", cyc);
        end
        if (ferr && prev_ferr) begin
            fails++;
            $display("FAIL ferr_width: ferr high two cycles at cycle %0d, required one", cyc);
        end
        if (dv) begin
            rx_q.push_back(rx_byte);
            dv_cnt++;
            last_dv_cyc = cyc;
        end
        if (ferr) ferr_cnt++;
        prev_dv   = dv;
        prev_ferr = ferr;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (CPB) @(posedge sysclk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Drives start, data LSB first, then the given stop level (left on the line).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        frame_cyc = cyc;
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            wait_bit();
        end
        rx = stop_bit;
        wait_bit();
    endtask

    task automatic wait_not_busy(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(posedge sysclk);
            #1;
            k++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL timeout: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int d0, f0, sz, exp_ferr, hold, gap;
        logic [7:0] b, data;
        logic good;

        vecs[0] = '{8'hA5, 1'b1, 5, 8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b1, 0, 8'h3C, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 3, 8'h00, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 7, 8'hFF, 1, 0};
        vecs[4] = '{8'h55, 1'b0, 2, 8'hFF, 0, 1};
        vecs[5] = '{8'h01, 1'b1, 9, 8'h01, 1, 0};
        vecs[6] = '{8'h80, 1'b1, 0, 8'h80, 1, 0};

        rst = 1'b1;
        en  = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        check("reset_byte", rx_byte, 0);
        check("reset_dv", dv, 0);
        check("reset_ferr", ferr, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle_cycles(4);

        // Vector table
        foreach (vecs[i]) begin
            d0 = dv_cnt;
            f0 = ferr_cnt;
            idle_cycles(vecs[i].gap);
            send_frame(vecs[i].data, vecs[i].stop_bit);
            idle_cycles(CPB);
            wait_not_busy($sformatf("vec%0d_idle", i), 4 * CPB);
            check($sformatf("vec%0d_byte", i), rx_byte, vecs[i].exp_byte);
            check($sformatf("vec%0d_dv", i), dv_cnt - d0, vecs[i].exp_dv);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            if (vecs[i].exp_dv == 1 && dv_cnt - d0 == 1)
                check($sformatf("vec%0d_latency", i), last_dv_cyc - frame_cyc, DV_LATENCY);
        end

        // Back-to-back frames with no idle bit
        rx_q.delete();
        d0 = dv_cnt;
        idle_cycles(4);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle_cycles(CPB);
        wait_not_busy("b2b_idle", 4 * CPB);
        check("b2b_dv", dv_cnt - d0, 2);
        sz = rx_q.size();
        check("b2b_count", sz, 2);
        if (sz >= 1) check("b2b_first", rx_q[0], 8'h3C);
        if (sz >= 2) check("b2b_second", rx_q[1], 8'hC3);

        // Four-cycle low glitch on the idle line
        b  = rx_byte;
        d0 = dv_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(posedge sysclk);
        #1;
        rx = 1'b1;
        check("glitch_busy", busy, 1);
        idle_cycles(2 * CPB);
        check("glitch_idle", busy, 0);
        check("glitch_dv", dv_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_byte", rx_byte, b);

        // Framing error followed by a held-low line
        b  = rx_byte;
        d0 = dv_cnt;
        f0 = ferr_cnt;
        idle_cycles(4);
        send_frame(8'h55, 1'b0);
        repeat (40) @(posedge sysclk);
        #1;
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_dv", dv_cnt - d0, 0);
        check("ferr_byte", rx_byte, b);
        check("ferr_break_busy", busy, 1);
        rx = 1'b1;
        wait_not_busy("ferr_release", CPB);
        check("ferr_single", ferr_cnt - f0, 1);

        // Enable dropped during data bit 3
        d0 = dv_cnt;
        f0 = ferr_cnt;
        idle_cycles(4);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (4 * CPB + 6) @(posedge sysclk);
                #1;
                check("en_drop_was_busy", busy, 1);
                en = 1'b0;
                @(posedge sysclk);
                #1;
                check("en_abort_busy", busy, 0);
            end
        join
        idle_cycles(CPB);
        check("en_abort_dv", dv_cnt - d0, 0);
        check("en_abort_ferr", ferr_cnt - f0, 0);
        check("en_abort_byte", rx_byte, 8'hC3);
        en = 1'b1;
        idle_cycles(4);
        send_frame(8'h12, 1'b1);
        idle_cycles(CPB);
        wait_not_busy("en_next_idle", 4 * CPB);
        check("en_next_byte", rx_byte, 8'h12);
        check("en_next_dv", dv_cnt - d0, 1);

        // Reset asserted during data bit 5
        d0 = dv_cnt;
        idle_cycles(4);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (6 * CPB + 8) @(posedge sysclk);
                #2;
                rst = 1'b1;
                #1;
                check("rst_byte", rx_byte, 0);
                check("rst_dv", dv, 0);
                check("rst_ferr", ferr, 0);
                check("rst_busy", busy, 0);
                repeat (3) @(posedge sysclk);
                #2;
                rst = 1'b0;
            end
        join
        idle_cycles(2 * CPB);
        check("rst_discard_dv", dv_cnt - d0, 0);
        check("rst_discard_busy", busy, 0);
        send_frame(8'h81, 1'b1);
        idle_cycles(CPB);
        wait_not_busy("rst_next_idle", 4 * CPB);
        check("rst_next_byte", rx_byte, 8'h81);
        check("rst_next_dv", dv_cnt - d0, 1);

        // Randomized frames against a frame-level model
        rx_q.delete();
        exp_q.delete();
        d0 = dv_cnt;
        f0 = ferr_cnt;
        exp_ferr = 0;
        idle_cycles(4);
        for (int n = 0; n < 24; n++) begin
            data = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 12);
            send_frame(data, good);
            if (good) begin
                exp_q.push_back(data);
            end else begin
                exp_ferr++;
                hold = $urandom_range(0, 30);
                repeat (hold) @(posedge sysclk);
                #1;
                idle_cycles(4);
            end
            idle_cycles(gap);
        end
        idle_cycles(CPB);
        wait_not_busy("rand_idle", 4 * CPB);
        check("rand_dv", dv_cnt - d0, exp_q.size());
        check("rand_ferr", ferr_cnt - f0, exp_ferr);
        sz = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < sz; i++)
            check($sformatf("rand_byte%0d", i), rx_q[i], exp_q[i]);
        if (exp_q.size() > 0)
            check("rand_last_byte", rx_byte, exp_q[exp_q.size() - 1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, meaning sysclk cycles per UART bit (125 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 8 (`DATA_WIDTH from uart_params.vh), meaning payload bits per frame.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 sysclk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 i_rx_en  input  1  receiver enable (the rx_on toggle from the top level).
REQ-007 i_rx_serial  input  1  asynchronous serial line; idles high.
REQ-008 o_rx_byte  output  DATA_WIDTH  last correctly framed byte, LSB = first data bit received.
REQ-009 o_rx_dv  output  1  one-cycle pulse: o_rx_byte has just been updated.
REQ-010 o_rx_ferr  output  1  one-cycle pulse: stop bit was sampled low (framing error).
REQ-011 o_rx_busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass i_rx_serial through a 2-flop synchronizer (reset value 1); the FSM uses only the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK; one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..DATA_WIDTH-1).
REQ-014 IDLE: on i_rx_en=1 and rx_s=0, SHALL go to START with counter=0; otherwise remain.
REQ-015 START: when counter reaches (CLKS_PER_BIT-1)/2 (integer division), SHALL sample rx_s: 0 -> DATA with counter=0, index=0; 1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: when counter reaches CLKS_PER_BIT-1, SHALL sample rx_s into shift bit [index], clear counter, then increment index; after index DATA_WIDTH-1 SHALL go to STOP.
REQ-017 STOP: when counter reaches CLKS_PER_BIT-1, SHALL sample rx_s: 1 -> load o_rx_byte from shift register, pulse o_rx_dv, go to IDLE; 0 -> pulse o_rx_ferr, leave o_rx_byte unchanged, go to BREAK.
REQ-018 BREAK: SHALL remain until rx_s=1, then go to IDLE; no new start is detected while in BREAK.
REQ-019 Latency: o_rx_dv SHALL assert exactly 3 cycles after the mid-stop-bit sample point of the raw line (2 synchronizer + 1 register).
REQ-020 o_rx_dv and o_rx_ferr SHALL never assert in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-021 i_rx_en=0 in any state other than IDLE SHALL abort to IDLE on the next edge with no pulse; o_rx_byte is retained.
REQ-022 A start edge arriving in the cycle STOP returns to IDLE SHALL be accepted (back-to-back frames, no idle bit required beyond the stop bit).
REQ-023 Counter SHALL be sized $clog2(CLKS_PER_BIT) bits and never wrap past CLKS_PER_BIT-1.

Reset
REQ-024 On rst=1, SHALL immediately force: state IDLE, counter 0, index 0, shift register 0, synchronizer flops 1, o_rx_byte 0, o_rx_dv 0, o_rx_ferr 0, o_rx_busy 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, the receiver SHALL wait for a fresh falling edge.

Structure
REQ-026 DATA_WIDTH, CLKS_PER_BIT default and FSM state encodings SHALL live in the shared header uart_params.vh, shared with uart_tx.
REQ-027 The 2-flop synchronizer SHALL be a sub-module named sync_2ff (reusable for button inputs in uart_top).
REQ-028 uart_rx SHALL be instantiable in uart_top with i_rx_en driven by rx_on and o_rx_dv driving led6_b.

Verification (bench uses CLKS_PER_BIT=16)
REQ-029 Send 0xA5 with correct stop bit, i_rx_en=1 -> o_rx_byte=0xA5, one o_rx_dv pulse, o_rx_ferr stays 0.
REQ-030 Send 0x3C then 0xC3 back-to-back (no idle gap) -> two dv pulses, bytes 0x3C then 0xC3.
REQ-031 Low glitch of 4 cycles on idle line -> FSM returns to IDLE, no pulses, o_rx_byte unchanged.
REQ-032 Send 0x55 with stop bit 0, line held low 40 more cycles -> one o_rx_ferr pulse, o_rx_byte unchanged, no new frame until line high.
REQ-033 Drop i_rx_en during data bit 3 of 0xFF -> immediate IDLE, no pulses; next frame 0x12 received correctly.
REQ-034 Assert rst during data bit 5 -> all outputs 0 within same cycle; subsequent frame 0x81 received correctly.
